sd_card_cmd_receiver: RTL and testbench

Card-side receiver for the SD CMD line: it deserialises the 48-bit command frames that `cmd_phys` shifts out on the CMD pin. It sits directly downstream of the host physical layer, in the card-model role. For each frame it detects the start bit, checks the transmission bit, the CRC7 and the end bit, then presents the command index and argument to the card logic through a strobe/ack handshake. Together with the card-side response serialiser, it closes the host CMD loop for self-checking benches.

---
 rtl/sd_card_cmd_receiver.sv | 116 +++++++++++
 tb/tb_sd_card_cmd_receiver.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_card_cmd_receiver.sv
// Card-side SD CMD line receiver: deserialises 48-bit command frames, checks
// transmission/end bits and CRC7, and hands index/argument over a strobe/ack handshake.
module sd_card_cmd_receiver #(
  parameter int FRAME_BITS = 48,
  parameter int CRC_BITS   = 7
) (
  input  logic        sd_clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        cmd_pin,
  input  logic        ack_in,
  output logic        strobe_out,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_argument,
  output logic        crc_error,
  output logic        frame_error,
  output logic        busy
);

  localparam int LAST_BIT = FRAME_BITS - 1;
  localparam int CRC_LAST = FRAME_BITS - CRC_BITS - 2;
  localparam logic [CRC_BITS-1:0] CRC_POLY = CRC_BITS'(7'h09);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECEIVE,
    S_PRESENT,
    S_WAIT_RELEASE
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nx;
  logic [5:0]              r_cnt;
  logic [CRC_BITS-1:0]     r_crc;
  logic [FRAME_BITS-3:0]   r_sr;
  logic [FRAME_BITS-2:0]   w_frame;
  logic [5:0]              r_cmd_index;
  logic [31:0]             r_cmd_argument;
  logic                    r_crc_error;
  logic                    r_frame_error;
  logic                    w_start;

  function automatic logic [CRC_BITS-1:0] crc7_step(input logic [CRC_BITS-1:0] crc,
                                                    input logic din);
    logic fb;
    fb = din ^ crc[CRC_BITS-1];
    return {crc[CRC_BITS-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

  // The start bit is never stored; w_frame holds frame bits 1..47, MSB = transmission bit.
  assign w_frame = {r_sr, cmd_pin};
  assign w_start = enable && !cmd_pin;

  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:         if (w_start) w_state_nx = S_RECEIVE;
      S_RECEIVE: begin
        if (!enable)                       w_state_nx = S_IDLE;
        else if (r_cnt == 6'(LAST_BIT))    w_state_nx = S_PRESENT;
      end
      S_PRESENT:      if (ack_in)  w_state_nx = S_WAIT_RELEASE;
      S_WAIT_RELEASE: if (!ack_in) w_state_nx = S_IDLE;
      default:        w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      r_cnt          <= '0;
      r_crc          <= '0;
      r_sr           <= '0;
      r_cmd_index    <= '0;
      r_cmd_argument <= '0;
      r_crc_error    <= 1'b0;
      r_frame_error  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_cnt <= 6'd1;
            r_crc <= crc7_step('0, cmd_pin);
            r_sr  <= '0;
          end
        end
        S_RECEIVE: begin
          if (enable) begin
            r_sr  <= {r_sr[FRAME_BITS-4:0], cmd_pin};
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt <= 6'(CRC_LAST)) r_crc <= crc7_step(r_crc, cmd_pin);
            if (r_cnt == 6'(LAST_BIT)) begin
              r_cmd_index    <= w_frame[FRAME_BITS-3 -: 6];
              r_cmd_argument <= w_frame[FRAME_BITS-9 -: 32];
              r_crc_error    <= (w_frame[CRC_BITS:1] != r_crc);
              r_frame_error  <= !w_frame[FRAME_BITS-2] || !w_frame[0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign strobe_out   = (r_state == S_PRESENT);
  assign busy         = (r_state != S_IDLE);
  assign cmd_index    = r_cmd_index;
  assign cmd_argument = r_cmd_argument;
  assign crc_error    = r_crc_error;
  assign frame_error  = r_frame_error;

endmodule

// File: tb/tb_sd_card_cmd_receiver.sv
// Directed bench for sd_card_cmd_receiver: known SD command frames with hand-computed fields.
module tb_sd_card_cmd_receiver;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        cmd_pin;
  logic        ack_in;
  logic        strobe_out;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_argument;
  logic        crc_error;
  logic        frame_error;
  logic        busy;

  int checks;
  int failures;

  sd_card_cmd_receiver dut (
    .sd_clock     (clk),
    .reset        (reset),
    .enable       (enable),
    .cmd_pin      (cmd_pin),
    .ack_in       (ack_in),
    .strobe_out   (strobe_out),
    .cmd_index    (cmd_index),
    .cmd_argument (cmd_argument),
    .crc_error    (crc_error),
    .frame_error  (frame_error),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [47:0] F_CMD0     = 48'h40_0000_0000_95;
  localparam logic [47:0] F_CMD8     = 48'h48_0000_01AA_87;
  localparam logic [47:0] F_CMD17    = 48'h51_0000_0000_55;
  localparam logic [47:0] F_CMD17_BC = 48'h51_0000_0000_57;
  localparam logic [47:0] F_CMD0_EB  = 48'h40_0000_0000_94;
  localparam logic [47:0] F_CMD0_TB  = 48'h00_0000_0000_95;

  // Drives frame bits first..last, one per cycle, changing on the falling edge.
  task automatic drive_bits(input logic [47:0] f, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      cmd_pin = f[47-i];
    end
  endtask

  task automatic send_frame(input logic [47:0] f, input string name);
    drive_bits(f, 0, 46);
    @(negedge clk);
    checks++;
    if (strobe_out !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s pre_end strobe/busy got=%b%b want=01", name, strobe_out, busy);
    end
    cmd_pin = f[0];
    @(negedge clk);
    cmd_pin = 1'b1;
    checks++;
    if (strobe_out !== 1'b1) begin
      failures++;
      $display("FAIL %s latency strobe got=%b want=1", name, strobe_out);
    end
  endtask

  task automatic ack_handshake(input int delay, input string name);
    repeat (delay) @(negedge clk);
    checks++;
    if (strobe_out !== 1'b1) begin
      failures++;
      $display("FAIL %s strobe_hold got=%b want=1", name, strobe_out);
    end
    ack_in = 1'b1;
    @(negedge clk);
    checks++;
    if (strobe_out !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s ack strobe/busy got=%b%b want=01", name, strobe_out, busy);
    end
    ack_in = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s release busy got=%b want=0", name, busy);
    end
  endtask

  task automatic check_fields(input string name, input logic [5:0] idx, input logic [31:0] arg,
                              input logic ce, input logic fe);
    checks++;
    if (cmd_index !== idx) begin
      failures++;
      $display("FAIL %s cmd_index got=%0d want=%0d", name, cmd_index, idx);
    end
    checks++;
    if (cmd_argument !== arg) begin
      failures++;
      $display("FAIL %s cmd_argument got=%h want=%h", name, cmd_argument, arg);
    end
    checks++;
    if (crc_error !== ce || frame_error !== fe) begin
      failures++;
      $display("FAIL %s crc/frame_error got=%b%b want=%b%b", name, crc_error, frame_error, ce, fe);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; cmd_pin = 1'b1; ack_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({strobe_out, busy, cmd_index, cmd_argument, crc_error, frame_error} !== 40'd0) begin
      failures++;
      $display("FAIL reset outputs got=%b%b %h %h %b%b want=all zero",
               strobe_out, busy, cmd_index, cmd_argument, crc_error, frame_error);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || strobe_out !== 1'b0) begin
      failures++;
      $display("FAIL reset idle busy/strobe got=%b%b want=00", busy, strobe_out);
    end
  endtask

  task automatic test_cmd0();
    send_frame(F_CMD0, "cmd0");
    check_fields("cmd0", 6'd0, 32'h0, 1'b0, 1'b0);
    ack_handshake(2, "cmd0");
  endtask

  task automatic test_back_to_back();
    send_frame(F_CMD8, "cmd8");
    check_fields("cmd8", 6'd8, 32'h0000_01AA, 1'b0, 1'b0);
    ack_handshake(0, "cmd8");
    send_frame(F_CMD17, "cmd17");
    check_fields("cmd17", 6'd17, 32'h0, 1'b0, 1'b0);
    ack_handshake(1, "cmd17");
  endtask

  task automatic test_crc_error();
    send_frame(F_CMD17_BC, "crc_bad");
    check_fields("crc_bad", 6'd17, 32'h0, 1'b1, 1'b0);
    ack_handshake(1, "crc_bad");
  endtask

  task automatic test_frame_error();
    send_frame(F_CMD0_EB, "end_bit");
    check_fields("end_bit", 6'd0, 32'h0, 1'b0, 1'b1);
    ack_handshake(1, "end_bit");
    // Zero transmission bit also changes the CRC input: all-zero CRC vs received 0x4A.
    send_frame(F_CMD0_TB, "tx_bit");
    check_fields("tx_bit", 6'd0, 32'h0, 1'b1, 1'b1);
    ack_handshake(1, "tx_bit");
  endtask

  task automatic test_enable_abort();
    int seen;
    drive_bits(F_CMD8, 0, 19);
    @(negedge clk);
    enable  = 1'b0;
    cmd_pin = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL abort busy got=%b want=0", busy);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (strobe_out === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL abort strobe_cycles got=%0d want=0", seen);
    end
    check_fields("abort_hold", 6'd0, 32'h0, 1'b1, 1'b1);
    enable = 1'b1;
    @(negedge clk);
    send_frame(F_CMD0, "after_abort");
    check_fields("after_abort", 6'd0, 32'h0, 1'b0, 1'b0);
    ack_handshake(1, "after_abort");
  endtask

  task automatic test_reset_mid_and_overlap();
    int seen;
    send_frame(F_CMD8, "pre_reset");
    ack_handshake(0, "pre_reset");
    drive_bits(F_CMD17, 0, 29);
    @(negedge clk);
    cmd_pin = 1'b1;
    reset   = 1'b0;
    #1;
    checks++;
    if ({strobe_out, busy, cmd_index, cmd_argument, crc_error, frame_error} !== 40'd0) begin
      failures++;
      $display("FAIL mid_reset outputs got=%b%b %h %h %b%b want=all zero",
               strobe_out, busy, cmd_index, cmd_argument, crc_error, frame_error);
    end
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL post_reset busy_cycles got=%0d want=0", seen);
    end
    send_frame(F_CMD17, "overlap_first");
    check_fields("overlap_first", 6'd17, 32'h0, 1'b0, 1'b0);
    drive_bits(F_CMD8, 0, 47);
    @(negedge clk);
    cmd_pin = 1'b1;
    checks++;
    if (strobe_out !== 1'b1) begin
      failures++;
      $display("FAIL overlap strobe got=%b want=1", strobe_out);
    end
    check_fields("overlap_hold", 6'd17, 32'h0, 1'b0, 1'b0);
    ack_handshake(0, "overlap");
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (strobe_out === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL overlap dropped active_cycles got=%0d want=0", seen);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_cmd0();
    test_back_to_back();
    test_crc_error();
    test_frame_error();
    test_enable_abort();
    test_reset_mid_and_overlap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
